add_sequencer: RTL
==================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the chunk width processed per cycle by the shared adder.
REQ-002 SHALL have parameter CHUNKS, default 4, meaning the number of chunks per operand; operand width N = WIDTH*CHUNKS.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  the requester presents an operation.
REQ-006 SHALL have port in_ready  output  1  the block accepts an operation this cycle.
REQ-007 SHALL have port op_a  input  N  the first operand.
REQ-008 SHALL have port op_b  input  N  the second operand.
REQ-009 SHALL have port sub  input  1  0 computes a+b, 1 computes a-b.
REQ-010 SHALL have port out_valid  output  1  the result is valid.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-012 SHALL have port sum  output  N  the result modulo 2^N.
REQ-013 SHALL have port cout  output  1  the carry out of bit N-1 (for subtract, 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  the two's-complement signed overflow flag.

Function
REQ-015 SHALL implement three states: IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; transfer occurs on an edge with in_valid&&in_ready.
REQ-017 SHALL, on transfer, register A=op_a, B=(sub ? ~op_b : op_b), carry=sub and chunk counter=0, clear the sum register, and enter RUN.
REQ-018 SHALL, on each RUN edge, add chunk[counter] of A and B plus carry through one WIDTH-bit adder, write that chunk's sum into sum[counter], load carry with the adder carry-out, and increment the counter.
REQ-019 SHALL enter DONE on the RUN edge that processes chunk CHUNKS-1, so out_valid rises exactly CHUNKS edges after the accepting edge.
REQ-020 SHALL set cout to the final registered carry.
REQ-021 SHALL set ovf = (A[N-1]==B[N-1]) && (sum[N-1]!=A[N-1]), where B is the effective (possibly inverted) operand.
REQ-022 SHALL hold out_valid=1 and sum/cout/ovf stable in DONE until an edge with out_ready=1, then return to IDLE.
REQ-023 SHALL accept no back-to-back overlap: the next transfer occurs no earlier than the edge after the DONE handshake, giving a throughput of one operation per CHUNKS+2 cycles with out_ready held high.
REQ-024 SHALL ignore in_valid, op_a, op_b and sub outside IDLE, and ignore out_ready outside DONE.
REQ-025 SHALL wrap the chunk counter with CHUNKS=1 supported (RUN lasts one edge).

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry=0 and counter=0, immediately and without waiting for clk.
REQ-027 SHALL abandon an operation in progress when reset is asserted in RUN or DONE, producing no result; the first transfer is possible on the first edge after rst_n rises.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) in a shared package with the default WIDTH/CHUNKS constants.
REQ-029 SHALL instantiate the existing carry-lookahead module adder exactly once with its WIDTH set to WIDTH as the only arithmetic sub-module; no N-bit adder SHALL be inferred.
REQ-030 SHALL size the counter as clog2(CHUNKS), minimum 1 bit.

Verification (WIDTH=4, CHUNKS=4)
REQ-031 SHALL cover add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0, out_valid 4 edges after accept.
REQ-032 SHALL cover sub 0x0000-0x0001 -> sum=0xFFFF, cout=0, ovf=0; and sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 SHALL cover add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-034 SHALL cover back-pressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout, then IDLE one edge after out_ready=1.
REQ-035 SHALL cover reset asserted asynchronously mid-RUN (after 2 chunks) -> out_valid=0 and in_ready=1 immediately; a subsequent 0x1234+0x1111 yields sum 0x2345.
REQ-036 SHALL cover changing op_a/op_b/sub during RUN -> result reflects only the values captured at accept.

Source files
------------

// File: rtl/add_sequencer_pkg.sv
// Shared constants and state encoding for the chunk-serial add/subtract sequencer.
package add_sequencer_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_CHUNKS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Counter width: clog2 of the chunk count, never narrower than one bit.
  function automatic int cnt_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// WIDTH-bit carry-lookahead adder: every carry is formed directly from
// generate/propagate terms rather than rippling from the previous bit.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             acc;
  logic             term;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i]).
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      acc = cin;
      for (int j = 0; j <= i; j++) acc = acc & p[j];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign s    = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/add_sequencer.sv
// Chunk-serial adder/subtractor: one shared WIDTH-bit adder processes one
// chunk per clock, least-significant chunk first.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// RUN   | adding chunk[cnt] each edge
// DONE  | result held with out_valid=1 until out_ready
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHUNKS = DEF_CHUNKS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*CHUNKS-1:0]  op_a,
  input  logic [WIDTH*CHUNKS-1:0]  op_b,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*CHUNKS-1:0]  sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int N  = WIDTH * CHUNKS;
  localparam int CW = cnt_width(CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  seq_state_t     state_q, state_d;
  logic [N-1:0]   a_q, b_q, sum_q;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_chunk, b_chunk, s_chunk;
  logic           c_chunk;
  logic           accept, last_chunk;

  assign accept     = (state_q == ST_IDLE) && in_valid;
  assign last_chunk = (cnt_q == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_chunk) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select the current chunk of each operand.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_chunk = a_q[i*WIDTH +: WIDTH];
        b_chunk = b_q[i*WIDTH +: WIDTH];
      end
    end
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .s    (s_chunk),
    .cout (c_chunk)
  );

  // Operand capture on accept, then one chunk of sum per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= sub ? ~op_b : op_b;
      sum_q   <= '0;
      carry_q <= sub;
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < CHUNKS; i++) begin
        if (cnt_q == CW'(i)) sum_q[i*WIDTH +: WIDTH] <= s_chunk;
      end
      carry_q <= c_chunk;
      cnt_q   <= last_chunk ? '0 : cnt_q + 1'b1;
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;
  assign ovf  = (a_q[N-1] == b_q[N-1]) && (sum_q[N-1] != a_q[N-1]);

endmodule
